// File: rtl/sright_seq.sv
// -----------------------------------------------------------------------------
// sright_seq
// Iterative right shifter. A request captures the operand, the shift amount and
// the fill mode. The result register then moves one bit to the right on each
// clock, logical (zero fill) or arithmetic (sign fill), until the requested
// amount has been applied. A start/busy/done handshake lets the processor
// control FSM stall while an SRL/SRA-type instruction is executing.
//
// Handshake (start/busy/done):
//   - start is sampled only on an edge where busy==0 (state IDLE). A sampled
//     start captures A, shamt and arith on that edge.
//   - busy is high from the edge after acceptance until the edge that returns
//     the block to IDLE. start while busy is ignored, and A/shamt/arith may
//     change freely.
//   - done is a one-cycle pulse in the final busy cycle. out is valid in that
//     cycle and holds until the next accepted start.
//   - Latency: done is high shamt+1 cycles after start is sampled. The next
//     start can be accepted on the edge that leaves DONE->IDLE's following
//     edge, i.e. the first edge where busy==0.
//
// Parameters:
//   WIDTH  data width in bits (default 32)
//   SHW    shift-amount width, WIDTH == 2**SHW (default 5)
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous active-high reset; drops any operation
//   start  in   1      request, sampled only when busy==0
//   A      in   WIDTH  operand, captured on an accepted start
//   shamt  in   SHW    shift amount 0..WIDTH-1, captured on an accepted start
//   arith  in   1      1 = sign fill (SRA), 0 = zero fill (SRL)
//   out    out  WIDTH  result register
//   busy   out  1      high in SHIFT and DONE
//   done   out  1      one-cycle pulse in DONE
//
// The FSM state is held in the named signal 'state' (type state_t) so that
// checkers can bind to it directly.
// -----------------------------------------------------------------------------
module sright_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] COUNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0] COUNT_ZERO = '0;

  // Registered state
  state_t             state;
  logic [WIDTH-1:0]   out_q;
  logic [SHW-1:0]     count_q;
  logic               fill_q;

  // Next-state values
  state_t             state_d;
  logic [WIDTH-1:0]   out_d;
  logic [SHW-1:0]     count_d;
  logic               fill_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      out_q   <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      state   <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      fill_q  <= fill_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    out_d   = out_q;
    count_d = count_q;
    fill_d  = fill_q;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          out_d   = A;
          count_d = shamt;
          // The fill bit is frozen here, so the sign of the captured operand
          // decides SRA fill even though A may change while busy.
          fill_d  = arith & A[WIDTH-1];
          state_d = (shamt == COUNT_ZERO) ? ST_DONE : ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        out_d   = {fill_q, out_q[WIDTH-1:1]};
        count_d = count_q - COUNT_ONE;
        // The edge taken with count==1 performs the last shift, so the count
        // never wraps below zero.
        if (count_q == COUNT_ONE) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out  = out_q;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sright_seq.sv
// -----------------------------------------------------------------------------
// tb_sright_seq
// Directed bench for sright_seq. A reference model tracks, per clock edge,
// what busy/done/out must be from the shift rules (result = A shifted right by
// the number of edges elapsed, logical or signed), and a compare process checks
// the DUT against it on every falling edge. A result queue checks out on every
// done pulse, and the directed tasks pin hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_sright_seq;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [4:0]   shamt = '0;
  logic         arith = 1'b0;
  logic [W-1:0] out;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  sright_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .shamt (shamt),
    .arith (arith),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] shr(input logic [W-1:0] a, input int k, input logic ar);
    logic signed [W-1:0] s;
    s = a;
    if (ar) shr = W'(s >>> k);
    else    shr = a >> k;
  endfunction

  int           e_cnt = 0;     // edges since time zero (clock edges only)
  bit           m_active = 1'b0;
  int           m_e0 = 0;
  int           m_sh = 0;
  logic [W-1:0] m_a = '0;
  logic         m_ar = 1'b0;
  logic [W-1:0] m_result = '0;

  logic [W-1:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_result = '0;
      exp_q.delete();
    end else begin
      e_cnt++;
      if (m_active) begin
        // Busy covers the shamt shifting edges plus the DONE cycle.
        if (e_cnt - m_e0 == m_sh + 1) m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1;
        m_e0     = e_cnt;
        m_sh     = int'(shamt);
        m_a      = A;
        m_ar     = arith;
        m_result = shr(A, int'(shamt), arith);
        exp_q.push_back(m_result);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge once reset has been released
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] e_out;
    logic         e_busy;
    logic         e_done;
    int           k;
    if (chk_en) begin
      k      = e_cnt - m_e0;
      e_busy = m_active;
      e_done = m_active && (k == m_sh);
      e_out  = m_active ? shr(m_a, k, m_ar) : m_result;
      check("model_busy", {31'b0, busy}, {31'b0, e_busy});
      check("model_done", {31'b0, done}, {31'b0, e_done});
      check("model_out", out, e_out);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          check("sb_result", out, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Wait for done from just after the accepting edge; returns cycles taken.
  task automatic wait_done(output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [4:0] sh,
                        input logic ar, input logic [W-1:0] exp_out);
    int n;
    @(posedge clk); #1;
    A = a; shamt = sh; arith = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operand inputs are free to change while busy.
    A = $urandom; shamt = 5'($urandom_range(0, 31)); arith = 1'($urandom_range(0, 1));
    wait_done(n);
    check({name, "_latency"}, 32'(n), 32'(int'(sh) + 1));
    check({name, "_out"}, out, exp_out);
    @(negedge clk);
    check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
    check({name, "_done_after"}, {31'b0, done}, 32'd0);
    check({name, "_out_hold"}, out, exp_out);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int  n;
    bit  saw_done;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_out", out, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);

    // Basic SRL / SRA, zero-amount and full-amount cases
    run_op("srl4",   32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000);
    run_op("sra4",   32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000);
    run_op("sh0",    32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678);
    run_op("sra31",  32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF);
    run_op("srl31",  32'h8000_0001, 5'd31, 1'b0, 32'h0000_0001);
    run_op("sra_pos",32'h7FFF_0000, 5'd8,  1'b1, 32'h007F_FF00);
    run_op("srl1",   32'h0000_0003, 5'd1,  1'b0, 32'h0000_0001);
    run_op("sra30",  32'hC000_0000, 5'd30, 1'b1, 32'hFFFF_FFFF);

    // start held high through an operation: second op waits for busy==0
    @(posedge clk); #1;
    A = 32'hA5A5_0000; shamt = 5'd3; arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    A = 32'h0000_F00F; shamt = 5'd2; arith = 1'b0;
    wait_done(n);
    check("hold_first_latency", 32'(n), 32'd4);
    check("hold_first_out", out, 32'hF4B4_A000);
    @(negedge clk);
    check("hold_idle_busy", {31'b0, busy}, 32'd0);
    check("hold_idle_out", out, 32'hF4B4_A000);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("hold_second_latency", 32'(n), 32'd3);
    check("hold_second_out", out, 32'h0000_3C03);

    // Asynchronous reset during a shamt=10 operation
    @(posedge clk); #1;
    A = 32'hF0F0_F0F0; shamt = 5'd10; arith = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", out, 32'h0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("no_done_after_rst", {31'b0, saw_done}, 32'd0);
    run_op("after_rst", 32'h8765_4321, 5'd5, 1'b1, 32'hFC3B_2A19);

    repeat (2) @(negedge clk);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
